// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencing states, register-file and reset constants.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use detector: an ID source operand matches a pending load destination.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rd,
    input  logic       rd_memtoreg,
    input  logic       rd_reg_en,
    output logic       hazard
);

    logic [4:0] src [2];
    logic [1:0] uses;
    logic [1:0] match;

    assign src[0]  = rs1;
    assign src[1]  = rs2;
    assign uses[0] = uses_rs1;
    assign uses[1] = uses_rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign match[gi] = uses[gi] && (src[gi] == rd);
    end

    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign hazard = rd_memtoreg && rd_reg_en && (rd != REG_ZERO) && (|match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core (RUN / FLUSH / MC_WAIT).
// Optional saturating perf counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT   = 64
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W      = 32
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memtoreg,
    input  logic       ex_reg_en,
    input  logic       ex_br_taken,
    input  logic       ex_mc_start,
    input  logic       mc_done,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mc_timeout,
    output logic       busy
`ifdef HAZ_PERF_CNT_EN
    , output logic [CNT_W-1:0] lu_stall_cnt
    , output logic [CNT_W-1:0] br_flush_cnt
    , output logic [CNT_W-1:0] mc_stall_cnt
`endif
);

    ctrl_state_e state_reg, state_next;
    logic [3:0]  flush_cnt_reg, flush_cnt_next;
    logic [7:0]  to_cnt_reg, to_cnt_next;
    logic        first_reg;
    logic        active;
    logic        lu_hazard;
    logic        lu_evt, br_evt, mc_evt, tmo_evt;

    hazard_cmp u_hazard_cmp (
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .uses_rs1    (id_uses_rs1),
        .uses_rs2    (id_uses_rs2),
        .rd          (ex_rd),
        .rd_memtoreg (ex_memtoreg),
        .rd_reg_en   (ex_reg_en),
        .hazard      (lu_hazard)
    );

    // Controls stay quiet while reset is low and for one cycle after release.
    assign active = reset && !first_reg;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        lu_evt         = 1'b0;
        br_evt         = 1'b0;
        mc_evt         = 1'b0;
        tmo_evt        = 1'b0;
        if (active) begin
            unique case (state_reg)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        br_evt = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next     = ST_FLUSH;
                            flush_cnt_next = 4'(FLUSH_CYCLES - 1);
                        end
                    end else if (ex_mc_start) begin
                        if (!mc_done) begin
                            mc_evt      = 1'b1;
                            state_next  = ST_MC_WAIT;
                            to_cnt_next = 8'd0;
                        end
                    end else if (lu_hazard) begin
                        lu_evt = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    br_evt         = 1'b1;
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                    if (flush_cnt_reg == 4'd1) begin
                        state_next = ST_RUN;
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done) begin
                        state_next  = ST_RUN;
                        to_cnt_next = 8'd0;
                    end else if (to_cnt_reg == 8'(MC_TIMEOUT - 1)) begin
                        tmo_evt     = 1'b1;
                        state_next  = ST_RUN;
                        to_cnt_next = 8'd0;
                    end else begin
                        mc_evt      = 1'b1;
                        to_cnt_next = to_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign pc_stall     = lu_evt | mc_evt;
    assign if_id_stall  = lu_evt | mc_evt;
    assign if_id_flush  = br_evt;
    assign id_ex_stall  = mc_evt;
    assign id_ex_flush  = br_evt | lu_evt | tmo_evt;
    // An aborted multi-cycle op must not reach MEM, so EX/MEM keeps its bubble on timeout.
    assign ex_mem_flush = mc_evt | tmo_evt;
    assign mc_timeout   = tmo_evt;
    assign busy         = active && (state_reg != ST_RUN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= 4'd0;
            to_cnt_reg    <= 8'd0;
            first_reg     <= 1'b1;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            first_reg     <= 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [2:0]       perf_evt;
    logic [CNT_W-1:0] perf_cnt_reg [3];

    assign perf_evt = {mc_evt, br_evt, lu_evt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        always_ff @(posedge clock) begin
            if (!reset) begin
                perf_cnt_reg[gi] <= '0;
            end else if (perf_evt[gi] && (perf_cnt_reg[gi] != '1)) begin
                perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign lu_stall_cnt = perf_cnt_reg[0];
    assign br_flush_cnt = perf_cnt_reg[1];
    assign mc_stall_cnt = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=3, MC_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_memtoreg, ex_reg_en, ex_br_taken, ex_mc_start, mc_done;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic       id_ex_flush, ex_mem_flush, mc_timeout, busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, br_flush_cnt, mc_stall_cnt;
`endif

    logic [7:0] outs;
    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .MC_TIMEOUT   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_memtoreg  (ex_memtoreg),
        .ex_reg_en    (ex_reg_en),
        .ex_br_taken  (ex_br_taken),
        .ex_mc_start  (ex_mc_start),
        .mc_done      (mc_done),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mc_timeout   (mc_timeout),
        .busy         (busy)
`ifdef HAZ_PERF_CNT_EN
        , .lu_stall_cnt (lu_stall_cnt)
        , .br_flush_cnt (br_flush_cnt)
        , .mc_stall_cnt (mc_stall_cnt)
`endif
    );

    // Bit order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_flush mc_timeout busy
    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_flush, mc_timeout, busy};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-14s observed=%b expected=%b", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge; outputs settle 1 time unit later.
    task automatic step(input logic br, input logic mcs, input logic done,
                        input logic ld, input logic regen, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
        @(negedge clock);
        ex_br_taken = br;
        ex_mc_start = mcs;
        mc_done     = done;
        ex_memtoreg = ld;
        ex_reg_en   = regen;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_uses_rs1 = u1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        idle();
        // Load-use hazard presented while reset is held, then in the release cycle.
        step(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        check("rst_hold", outs, 8'b0000_0000);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_first", outs, 8'b0000_0000);

        step(0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        check("lu_rs1", outs, 8'b1100_1000);
        idle();
        check("lu_clear", outs, 8'b0000_0000);
        step(0, 0, 0, 1, 1, 5'd7, 5'd3, 1, 5'd7, 1);
        check("lu_rs2", outs, 8'b1100_1000);
        step(0, 0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        check("lu_x0", outs, 8'b0000_0000);
        step(0, 0, 0, 1, 1, 5'd5, 5'd5, 0, 5'd9, 1);
        check("lu_nouse", outs, 8'b0000_0000);
        step(0, 0, 0, 1, 0, 5'd5, 5'd5, 1, 5'd0, 0);
        check("lu_noregen", outs, 8'b0000_0000);
        step(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        check("lu_noload", outs, 8'b0000_0000);

        // Taken branch: three flush cycles; a branch and LU inside FLUSH are ignored.
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        check("br_run", outs, 8'b0010_1000);
        idle();
        check("br_f1", outs, 8'b0010_1001);
        step(1, 1, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0);
        check("br_f2", outs, 8'b0010_1001);
        idle();
        check("br_done", outs, 8'b0000_0000);

        // Multi-cycle op finishing on the fifth cycle after start.
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        check("mc_start", outs, 8'b1101_0100);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) step(1, 0, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0);
            else        idle();
            check($sformatf("mc_wait%0d", i), outs, 8'b1101_0101);
        end
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        check("mc_done", outs, 8'b0000_0001);
        idle();
        check("mc_run", outs, 8'b0000_0000);

        step(0, 1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        check("mc_single", outs, 8'b0000_0000);
        idle();
        check("mc_single_nx", outs, 8'b0000_0000);

        // Timeout: eighth MC_WAIT cycle aborts (ex_mem_flush masked there).
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        check("tmo_start", outs, 8'b1101_0100);
        for (int i = 1; i <= 7; i++) begin
            idle();
            check($sformatf("tmo_wait%0d", i), outs, 8'b1101_0101);
        end
        idle();
        check("tmo_pulse", outs & 8'b1111_1011, 8'b0000_1011);
        idle();
        check("tmo_run", outs, 8'b0000_0000);

        // Branch outranks multi-cycle start and load-use in the same cycle.
        step(1, 1, 0, 1, 1, 5'd8, 5'd8, 1, 5'd0, 0);
        check("br_prio", outs, 8'b0010_1000);
        idle();
        check("br_prio_f1", outs, 8'b0010_1001);
        idle();
        check("br_prio_f2", outs, 8'b0010_1001);
        idle();
        check("br_prio_end", outs, 8'b0000_0000);

        // Reset during the third MC_WAIT cycle.
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        check("rm_start", outs, 8'b1101_0100);
        idle();
        check("rm_wait1", outs, 8'b1101_0101);
        idle();
        check("rm_wait2", outs, 8'b1101_0101);
        idle();
        reset = 1'b0;
        #1;
        check("rm_hold", outs, 8'b0000_0000);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rm_first", outs, 8'b0000_0000);
        for (int i = 1; i <= 8; i++) begin
            idle();
            check($sformatf("rm_run%0d", i), outs, 8'b0000_0000);
        end
        step(0, 0, 0, 1, 1, 5'd5, 5'd0, 0, 5'd5, 1);
        check("rm_lu", outs, 8'b1100_1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
